// File: rtl/posit_mult_construct_if.sv
// Handshake bundle between the posit multiplier arithmetic stage, this output stage and
// the downstream consumer. The slave modport is the output stage's view.
interface posit_mult_construct_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  parameter int unsigned RS = $clog2(N)
);
  logic                in_valid;
  logic                in_ready;
  logic [2*N-1:0]      Mult_Mant_N;
  logic [ES-1:0]       E_O;
  logic signed [RS+2:0] R_O;
  logic signed [RS+2:0] sumR;
  logic                inf;
  logic                zero;
  logic                Sign;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0]        Result;

  modport master (
    output in_valid, Mult_Mant_N, E_O, R_O, sumR, inf, zero, Sign, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, Mult_Mant_N, E_O, R_O, sumR, inf, zero, Sign, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/posit_mult_construct.sv
// Posit multiplier output stage: regime/body assembly (stage 1), then round-to-nearest-even,
// saturation and sign application (stage 2), with valid/ready on both sides.
module posit_mult_construct #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  parameter int unsigned RS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit_mult_construct_if.slave bus
);

  localparam int unsigned TW = ES + 2 * N - 1;  // exponent + fraction tail
  localparam int unsigned BW = 2 * N + ES + N;  // assembly field width
  localparam int unsigned PW = BW - TW - 2;
  localparam logic signed [RS+2:0] SatLimit = (RS + 3)'(N - 1);
  localparam logic signed [RS+2:0] RunOne   = (RS + 3)'(1);

  logic s1_valid, s2_valid, s2_ready, accept;

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 1 combinational assembly
  logic                 neg_regime, sat;
  logic [RS+2:0]        shamt;
  logic signed [BW-1:0] field, shifted;
  logic [N-2:0]         body_d;
  logic                 guard_d, sticky_d;
  logic                 unused_hidden;

  assign unused_hidden = bus.Mult_Mant_N[2*N-1];

  always_comb begin
    neg_regime = bus.sumR[RS+2];
    sat        = bus.R_O >= SatLimit;
    shamt      = (bus.R_O > RunOne) ? $unsigned(bus.R_O - RunOne) : '0;
    // Seed with one regime bit plus its terminator; the arithmetic shift replicates the run.
    field      = {~neg_regime, neg_regime, bus.E_O, bus.Mult_Mant_N[2*N-2:0], {PW{1'b0}}};
    shifted    = field >>> shamt;
    body_d     = shifted[BW-1 -: N-1];
    guard_d    = shifted[BW-N];
    sticky_d   = |shifted[BW-N-1:0];
    if (sat) begin
      body_d   = neg_regime ? (N - 1)'(1) : '1;
      guard_d  = 1'b0;
      sticky_d = 1'b0;
    end
  end

  logic [N-2:0] s1_body;
  logic         s1_guard, s1_sticky, s1_inf, s1_zero, s1_sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_body   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sign   <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_body   <= body_d;
        s1_guard  <= guard_d;
        s1_sticky <= sticky_d;
        s1_inf    <= bus.inf;
        s1_zero   <= bus.zero;
        s1_sign   <= bus.Sign;
      end
    end
  end

  // Stage 2 combinational rounding and sign
  logic         inc;
  logic [N-1:0] rounded, mag, result_d;
  logic [N-2:0] body_r;

  always_comb begin
    inc     = s1_guard && (s1_sticky || s1_body[0]);
    rounded = {1'b0, s1_body} + N'(inc);
    body_r  = rounded[N-1] ? '1 : rounded[N-2:0];
    // A non-zero product must never collapse to zero.
    if (body_r == '0) body_r = (N - 1)'(1);
    mag      = {1'b0, body_r};
    result_d = s1_sign ? (~mag + N'(1)) : mag;
    if (s1_inf) begin
      result_d = {1'b1, {(N - 1){1'b0}}};
    end else if (s1_zero) begin
      result_d = '0;
    end
  end

  logic [N-1:0] s2_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_result <= result_d;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.Result    = s2_result;

endmodule

// File: tb/tb_posit_mult_construct.sv
// Directed bench for posit_mult_construct: table of hand-computed vectors plus streaming,
// backpressure and asynchronous mid-flight reset sequences.
module tb_posit_mult_construct;
  localparam int unsigned N  = 32;
  localparam int unsigned ES = 2;
  localparam int unsigned RS = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_mult_construct_if #(.N(N), .ES(ES), .RS(RS)) bus ();

  posit_mult_construct #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] mant;
    logic [1:0]  e;
    logic [7:0]  r;
    logic [7:0]  s;
    logic        inf;
    logic        zero;
    logic        sign;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Mult_Mant_N = v.mant;
    bus.E_O         = v.e;
    bus.R_O         = v.r;
    bus.sumR        = v.s;
    bus.inf         = v.inf;
    bus.zero        = v.zero;
    bus.Sign        = v.sign;
  endtask

  // Called just after a rising edge with out_ready=1; leaves just after a rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    logic took;
    int   n;
    took = 1'b0;
    n    = 0;
    drive(v);
    bus.in_valid = 1'b1;
    while (!took && n < 20) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("v%0d accept", idx), 32'(took), 32'd1);
    @(negedge clk);
    check($sformatf("v%0d valid after 1 cycle", idx), 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d valid after 2 cycles", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("v%0d result", idx), bus.Result, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res_q[$];
    int          cyc_q[$];
    int          sidx[4];
    int          bp[3];
    int          acc;
    logic        took;
    logic [31:0] held;

    vecs[0]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h4000_0000};
    vecs[1]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b1, 32'hC000_0000};
    vecs[2]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd1,  8'hFF,  1'b0, 1'b0, 1'b0, 32'h2000_0000};
    vecs[3]  = '{64'h8000_0018_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h4000_0002};
    vecs[4]  = '{64'h8000_0008_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h4000_0000};
    vecs[5]  = '{64'h8000_0008_0000_0001, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h4000_0001};
    vecs[6]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd41, 8'd40,  1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF};
    vecs[7]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd40, 8'hD8,  1'b0, 1'b0, 1'b0, 32'h0000_0001};
    vecs[8]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd40, 8'hD8,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[9]  = '{64'h8000_0000_0000_0000, 2'd0, 8'd1,  8'd0,   1'b1, 1'b1, 1'b1, 32'h8000_0000};
    vecs[10] = '{64'h8000_0000_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[11] = '{64'h8000_0000_0000_0000, 2'd3, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h5800_0000};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 32'h6000_0000};
    vecs[13] = '{64'h8000_0000_0000_0000, 2'd3, 8'd30, 8'hE2,  1'b0, 1'b0, 1'b0, 32'h0000_0002};
    vecs[14] = '{64'h8000_0000_0000_0000, 2'd0, 8'd30, 8'd30,  1'b0, 1'b0, 1'b0, 32'h7FFF_FFFE};
    vecs[15] = '{64'h8000_0018_0000_0000, 2'd0, 8'd1,  8'd0,   1'b0, 1'b0, 1'b1, 32'hBFFF_FFFE};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(vecs[0]);
    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset Result", bus.Result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back stream
    sidx = '{0, 3, 6, 9};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          drive(vecs[sidx[i]]);
          bus.in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            res_q.push_back(bus.Result);
            cyc_q.push_back(c);
          end
        end
      end
    join
    check("stream count", 32'(res_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream item %0d", i),
            (i < res_q.size()) ? res_q[i] : 32'hDEAD_BEEF, vecs[sidx[i]].exp);
      if (i > 0 && i < cyc_q.size())
        check($sformatf("stream gap %0d", i), 32'(cyc_q[i] - cyc_q[i-1]), 32'd1);
    end
    @(posedge clk);
    #1;

    // Backpressure: both stages fill, then in_ready drops
    bp            = '{2, 5, 7};
    bus.out_ready = 1'b0;
    acc           = 0;
    held          = '0;
    for (int c = 0; c < 5; c++) begin
      drive(vecs[bp[(acc < 3) ? acc : 2]]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      took = bus.in_ready;
      if (c == 2) held = bus.Result;
      @(posedge clk);
      #1;
      if (took) acc++;
    end
    bus.in_valid = 1'b0;
    check("bp accepts", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    check("bp out_valid held", 32'(bus.out_valid), 32'd1);
    check("bp Result first", held, vecs[bp[0]].exp);
    check("bp Result stable", bus.Result, held);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    res_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) res_q.push_back(bus.Result);
    end
    check("bp drain count", 32'(res_q.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      check($sformatf("bp drain item %0d", i),
            (i < res_q.size()) ? res_q[i] : 32'hDEAD_BEEF, vecs[bp[i]].exp);
    @(posedge clk);
    #1;

    // Asynchronous reset with two items in flight
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(vecs[3]);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(bus.out_valid), 32'd0);
    check("async reset Result", bus.Result, 32'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("no replay after reset", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    run_vec(vecs[11], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/posit_mult_construct.md
Name: posit_mult_construct

Overview:
- Output stage of the posit multiplier; sits directly downstream of the multiplication arithmetic stage.
- Consumes that stage's outputs: normalised mantissa product, exponent, regime run length, signed regime sum, sign and special flags.
- Assembles the posit bit string, applies round-to-nearest-even, saturates, applies sign, and returns an N-bit posit.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 32, posit word width.
- ES, 2, exponent field width.
- RS, $clog2(N), regime count width; same derivation as the arithmetic stage.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept operands this cycle.
- Mult_Mant_N  input  2N  normalised product; bit 2N-1 is the hidden 1.
- E_O  input  ES  result exponent field.
- R_O  input  RS+3 signed  regime run length.
- sumR  input  RS+3 signed  regime sum; its MSB selects negative regime.
- inf  input  1  either operand NaR.
- zero  input  1  either operand zero.
- Sign  input  1  result sign.
- out_valid  output  1  Result valid.
- out_ready  input  1  downstream accepts Result.
- Result  output  N  final posit.

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valid flags clear, all pipeline registers clear, out_valid=0, Result=0. in_ready=1 one cycle after rst_n deasserts.
- Reset mid-operation: any in-flight data is discarded. Nothing is replayed.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - in_ready = !s1_valid | s2_ready. s2_ready = !s2_valid | out_ready.
  - Full throughput is one result per cycle. Latency is 2 cycles from input accept to out_valid.
  - Under backpressure (out_ready=0), Result and out_valid hold stable. Both stages fill, then in_ready drops.
  - Inputs must not be sampled unless in_valid & in_ready.
- Stage 1 (regime/body assembly, registered):
  - sumR[RS+2]=0: regime = R_O ones then one 0.
  - sumR[RS+2]=1: regime = R_O zeros then one 1.
  - Regime length L = R_O+1.
  - Unrounded body = {regime, E_O, Mult_Mant_N[2N-2:0]}, left-aligned in a 2N+ES+N wide field.
  - Registered values: top N-1 body bits, guard bit (next bit), sticky bit (OR of all remaining bits).
  - Saturation: if R_O >= N-1, set a sat flag. The body is forced to all ones (sumR>=0, maxpos) or 0...01 (sumR<0, minpos). Guard and sticky are forced to 0.
  - inf and zero are registered alongside.
- Stage 2 (round/sign, registered):
  - Round-to-nearest-even: increment when guard & (sticky | lsb).
  - Increment overflow past all ones in N-1 bits clamps to maxpos.
  - A non-zero product never rounds to 0; a body of 0 is replaced with minpos.
  - Result = Sign ? two's complement of {1'b0, body} : {1'b0, body}.
- Special-case priority:
  - inf: Result = 1 followed by N-1 zeros (NaR), ignoring Sign.
  - else zero: Result = 0.
  - else the normal path above.
- No combinational path from input data to Result. Only in_ready depends combinationally on out_ready.

Test Plan (N=32, ES=2):
- 1.0×1.0: Mult_Mant_N=0x8000_0000_0000_0000, E_O=0, sumR=0, R_O=1, Sign=0 -> Result 0x4000_0000 exactly 2 cycles after accept. The same operands with Sign=1 -> 0xC000_0000.
- Negative regime: sumR=-1, R_O=1, E_O=0, mantissa 0x8000_0000_0000_0000 -> 0x2000_0000.
- Rounding, with sumR=0, R_O=1, E_O=0:
  - Mult_Mant_N=0x8000_0018_0000_0000 (lsb=1, guard=1, sticky=0) -> 0x4000_0002.
  - Mult_Mant_N=0x8000_0008_0000_0000 (tie, lsb=0) -> 0x4000_0000.
  - Mult_Mant_N=0x8000_0008_0000_0001 -> 0x4000_0001.
- Saturation and specials:
  - sumR=40, R_O=41 -> 0x7FFF_FFFF.
  - sumR=-40, R_O=40 -> 0x0000_0001; the same with Sign=1 -> 0xFFFF_FFFF.
  - inf=1 & zero=1 -> 0x8000_0000.
  - zero=1 alone -> 0x0000_0000.
- Handshake:
  - Stream 4 back-to-back operands with out_ready=1 -> 4 results on consecutive cycles, in order.
  - Hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, and Result stays stable.
  - Release out_ready -> no loss or duplication.
- Reset mid-flight: pull rst_n low asynchronously with 2 items in flight -> out_valid=0 and Result=0 immediately, without waiting for a clock edge. After release, the first new operand gives a correct result 2 cycles after accept.
